// File: rtl/rob_queue.sv
// rob_queue: circular reorder buffer; allocates in program order, captures CDB results, presents head to commit
module rob_queue #(
    parameter int DEPTH       = 8,
    parameter int ROB_IDX_LEN = 3,
    parameter int XLEN        = 64,
    parameter int EXCEPT_LEN  = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [31:0]            issue_instr_i,
    input  logic [XLEN-1:0]        issue_pc_i,
    input  logic [4:0]             issue_rd_idx_i,
    input  logic                   issue_res_ready_i,
    input  logic                   issue_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]  issue_except_code_i,
    output logic [ROB_IDX_LEN-1:0] issue_idx_o,
    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_idx_i,
    input  logic [XLEN-1:0]        cdb_value_i,
    input  logic                   cdb_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]  cdb_except_code_i,
    output logic                   comm_valid_o,
    input  logic                   comm_ready_i,
    output logic [31:0]            comm_instr_o,
    output logic [XLEN-1:0]        comm_pc_o,
    output logic [4:0]             comm_rd_idx_o,
    output logic [XLEN-1:0]        comm_value_o,
    output logic                   comm_except_raised_o,
    output logic [EXCEPT_LEN-1:0]  comm_except_code_o,
    output logic [ROB_IDX_LEN-1:0] comm_head_idx_o
);
    localparam logic [ROB_IDX_LEN:0] L_FULL = (ROB_IDX_LEN+1)'(DEPTH);

    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_res_ready;
    logic [31:0]            r_instr  [DEPTH];
    logic [XLEN-1:0]        r_pc     [DEPTH];
    logic [4:0]             r_rd     [DEPTH];
    logic [XLEN-1:0]        r_value  [DEPTH];
    logic                   r_exc    [DEPTH];
    logic [EXCEPT_LEN-1:0]  r_code   [DEPTH];
    logic [ROB_IDX_LEN-1:0] r_head;
    logic [ROB_IDX_LEN-1:0] r_tail;
    logic [ROB_IDX_LEN:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_cdb;
    logic w_head_ok;

    assign issue_ready_o   = r_count != L_FULL;
    assign issue_idx_o     = r_tail;
    assign comm_head_idx_o = r_head;
    assign w_head_ok       = r_valid[r_head] & r_res_ready[r_head];
    assign w_push          = issue_valid_i & issue_ready_o;
    assign w_pop           = w_head_ok & comm_ready_i;
    assign w_cdb           = cdb_valid_i & r_valid[cdb_idx_i] & ~r_res_ready[cdb_idx_i];

    // Head entry presented to commit, zeroed while not committable
    always_comb begin
        comm_valid_o         = w_head_ok;
        comm_instr_o         = w_head_ok ? r_instr[r_head] : '0;
        comm_pc_o            = w_head_ok ? r_pc[r_head]    : '0;
        comm_rd_idx_o        = w_head_ok ? r_rd[r_head]    : '0;
        comm_value_o         = w_head_ok ? r_value[r_head] : '0;
        comm_except_raised_o = w_head_ok ? r_exc[r_head]   : 1'b0;
        comm_except_code_o   = w_head_ok ? r_code[r_head]  : '0;
    end

    // Occupancy state: pointers, count and per-entry valid/ready flags; flush behaves like reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_res_ready <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else if (flush_i) begin
            r_valid     <= '0;
            r_res_ready <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            if (w_cdb) r_res_ready[cdb_idx_i] <= 1'b1;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail]     <= 1'b1;
                r_res_ready[r_tail] <= issue_res_ready_i | issue_except_raised_i;
                r_tail              <= r_tail + 1'b1;
            end
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Entry payload; only meaningful while the entry is valid, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (!flush_i && w_push) begin
            r_instr[r_tail] <= issue_instr_i;
            r_pc[r_tail]    <= issue_pc_i;
            r_rd[r_tail]    <= issue_rd_idx_i;
            r_value[r_tail] <= '0;
            r_exc[r_tail]   <= issue_except_raised_i;
            r_code[r_tail]  <= issue_except_code_i;
        end
        if (!flush_i && w_cdb) begin
            r_value[cdb_idx_i] <= cdb_value_i;
            r_exc[cdb_idx_i]   <= cdb_except_raised_i;
            r_code[cdb_idx_i]  <= cdb_except_code_i;
        end
    end
endmodule
